// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and RX byte-present decode for the UART FIFO bridge
package uart_pkg;

    localparam int          UART_BYTE_W    = 8;
    localparam logic [31:0] UART_DAT_EMPTY = 32'hFFFF_FFFF;

    // The core reports a byte as {24'h0, byte}; any non-zero upper bits mean no byte.
    function automatic logic uart_rx_avail(input logic [31:0] i_dat);
        return (i_dat[31:UART_BYTE_W] == '0);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with combinational head and occupancy level
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra MSB so equal indices can be told apart as full or empty.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - TX/RX byte FIFOs between the bus and the UART data register
// Optional macro UART_BRIDGE_RX_DROP_EN: drain the core when RX is full, dropping the byte and flagging overrun.
module uart_fifo_bridge
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [UART_BYTE_W-1:0]        tx_data,
    output logic                          tx_ready,
    output logic                          rx_valid,
    output logic [UART_BYTE_W-1:0]        rx_data,
    input  logic                          rx_ready,
    output logic [$clog2(TX_DEPTH):0]     tx_level,
    output logic [$clog2(RX_DEPTH):0]     rx_level,
    output logic                          rx_overrun,
    input  logic                          rx_overrun_clr,
    output logic                          uart_dat_we,
    output logic [UART_BYTE_W-1:0]        uart_dat_di,
    input  logic                          uart_dat_wait,
    output logic                          uart_dat_re,
    input  logic [31:0]                   uart_dat_do
);

    logic [UART_BYTE_W-1:0] w_tx_head;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic                   w_tx_pop;
    logic [UART_BYTE_W-1:0] w_rx_head;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic                   w_rx_avail;
    logic                   w_rx_push;

    assign tx_ready    = !w_tx_full;
    assign uart_dat_we = !w_tx_empty;
    assign uart_dat_di = w_tx_empty ? '0 : w_tx_head;
    assign w_tx_pop    = uart_dat_we && !uart_dat_wait;

    uart_sync_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (tx_valid),
        .i_push_data (tx_data),
        .i_pop       (w_tx_pop),
        .o_head      (w_tx_head),
        .o_full      (w_tx_full),
        .o_empty     (w_tx_empty),
        .o_level     (tx_level)
    );

    assign w_rx_avail = uart_rx_avail(uart_dat_do);
    assign w_rx_push  = w_rx_avail && !w_rx_full;
    assign rx_valid   = !w_rx_empty;
    assign rx_data    = w_rx_empty ? '0 : w_rx_head;

    uart_sync_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (UART_BYTE_W)
    ) u_rx_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_rx_push),
        .i_push_data (uart_dat_do[UART_BYTE_W-1:0]),
        .i_pop       (rx_ready),
        .o_head      (w_rx_head),
        .o_full      (w_rx_full),
        .o_empty     (w_rx_empty),
        .o_level     (rx_level)
    );

`ifdef UART_BRIDGE_RX_DROP_EN
    logic r_rx_overrun;

    assign uart_dat_re = w_rx_avail;
    assign rx_overrun  = r_rx_overrun;

    // A fresh drop outranks a coincident clear so no overrun goes unreported.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_overrun <= 1'b0;
        end else if (w_rx_avail && w_rx_full) begin
            r_rx_overrun <= 1'b1;
        end else if (rx_overrun_clr) begin
            r_rx_overrun <= 1'b0;
        end
    end
`else
    logic w_unused_clr;

    assign uart_dat_re  = w_rx_push;
    assign rx_overrun   = 1'b0;
    assign w_unused_clr = rx_overrun_clr;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb/tb_uart_fifo_bridge.sv - randomized self-checking bench for uart_fifo_bridge against a queue model
module tb_uart_fifo_bridge;

    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;
`ifdef UART_BRIDGE_RX_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [4:0]  tx_level;
    logic [4:0]  rx_level;
    logic        rx_overrun;
    logic        rx_overrun_clr;
    logic        uart_dat_we;
    logic [7:0]  uart_dat_di;
    logic        uart_dat_wait;
    logic        uart_dat_re;
    logic [31:0] uart_dat_do;

    always #5 clk = ~clk;

    uart_fifo_bridge #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk            (clk),
        .reset          (reset),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .rx_overrun     (rx_overrun),
        .rx_overrun_clr (rx_overrun_clr),
        .uart_dat_we    (uart_dat_we),
        .uart_dat_di    (uart_dat_di),
        .uart_dat_wait  (uart_dat_wait),
        .uart_dat_re    (uart_dat_re),
        .uart_dat_do    (uart_dat_do)
    );

    bit [7:0] tq[$];
    bit [7:0] rq[$];
    bit       m_ovr;
    int       errors = 0;
    int       checks = 0;

    task automatic set_in(input bit tv, input bit [7:0] td, input bit w,
                          input bit [31:0] dd, input bit rr, input bit clr);
        tx_valid       = tv;
        tx_data        = td;
        uart_dat_wait  = w;
        uart_dat_do    = dd;
        rx_ready       = rr;
        rx_overrun_clr = clr;
        #1;
    endtask

    // Advance one clock and apply the behavioural rules to the queues.
    task automatic tick();
        bit tpush, tpop, avail, rpush, rpop, oset, clr, rst;
        bit [7:0] tdv, rdv;
        rst   = reset;
        tpush = tx_valid && (tq.size() < TXD);
        tpop  = (tq.size() > 0) && !uart_dat_wait;
        avail = (uart_dat_do[31:8] == 24'h0);
        rpush = avail && (rq.size() < RXD);
        rpop  = (rq.size() > 0) && rx_ready;
        oset  = DROP && avail && (rq.size() == RXD);
        clr   = rx_overrun_clr;
        tdv   = tx_data;
        rdv   = uart_dat_do[7:0];
        @(posedge clk);
        if (rst) begin
            tq.delete();
            rq.delete();
            m_ovr = 1'b0;
        end else begin
            if (tpop) void'(tq.pop_front());
            if (tpush) tq.push_back(tdv);
            if (rpop) void'(rq.pop_front());
            if (rpush) rq.push_back(rdv);
            if (oset) m_ovr = 1'b1;
            else if (clr && DROP) m_ovr = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 8'h00, 0, EMPTY, 0, 0);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL reset_tx_level got=%0d want=0", tx_level); end
        checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL reset_rx_level got=%0d want=0", rx_level); end
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b want=0", rx_overrun); end
        checks++; if (uart_dat_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", uart_dat_we); end
        checks++; if (uart_dat_di !== 8'h00) begin errors++; $display("FAIL reset_di got=%h want=00", uart_dat_di); end
        checks++; if (uart_dat_re !== 1'b0) begin errors++; $display("FAIL reset_re got=%b want=0", uart_dat_re); end
    endtask

    task automatic test_tx_order();
        bit [7:0] b [3];
        b[0] = 8'h55; b[1] = 8'hA3; b[2] = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            set_in(1, b[i], 1, EMPTY, 0, 0);
            tick();
            checks++; if (tx_level !== 5'(i + 1)) begin errors++; $display("FAIL txo_level_fill got=%0d want=%0d", tx_level, i + 1); end
            checks++; if (uart_dat_we !== 1'b1) begin errors++; $display("FAIL txo_we_latency got=%b want=1", uart_dat_we); end
        end
        for (int i = 0; i < 20; i++) begin
            set_in(0, 8'h00, 1, EMPTY, 0, 0);
            checks++; if (uart_dat_di !== 8'h55) begin errors++; $display("FAIL txo_hold_di got=%h want=55", uart_dat_di); end
            tick();
        end
        checks++; if (tx_level !== 5'd3) begin errors++; $display("FAIL txo_hold_level got=%0d want=3", tx_level); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 8'h00, 0, EMPTY, 0, 0);
            checks++; if (uart_dat_di !== b[i]) begin errors++; $display("FAIL txo_drain_di got=%h want=%h", uart_dat_di, b[i]); end
            checks++; if (tx_level !== 5'(3 - i)) begin errors++; $display("FAIL txo_drain_level got=%0d want=%0d", tx_level, 3 - i); end
            tick();
        end
        checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL txo_empty_level got=%0d want=0", tx_level); end
        checks++; if (uart_dat_we !== 1'b0) begin errors++; $display("FAIL txo_empty_we got=%b want=0", uart_dat_we); end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < TXD; i++) begin
            set_in(1, 8'($urandom_range(255)), 1, EMPTY, 0, 0);
            tick();
        end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL txf_ready got=%b want=0", tx_ready); end
        checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL txf_level got=%0d want=16", tx_level); end
        set_in(1, 8'hAA, 1, EMPTY, 0, 0);
        tick();
        checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL txf_17th_level got=%0d want=16", tx_level); end
        for (int i = 0; i < TXD; i++) begin
            set_in(0, 8'h00, 0, EMPTY, 0, 0);
            checks++; if (uart_dat_di !== tq[0]) begin errors++; $display("FAIL txf_drain_di got=%h want=%h", uart_dat_di, tq[0]); end
            tick();
        end
        checks++; if (uart_dat_we !== 1'b0) begin errors++; $display("FAIL txf_drained_we got=%b want=0", uart_dat_we); end
    endtask

    task automatic test_rx_single();
        set_in(0, 8'h00, 0, 32'h0000_003C, 0, 0);
        checks++; if (uart_dat_re !== 1'b1) begin errors++; $display("FAIL rxs_re got=%b want=1", uart_dat_re); end
        tick();
        set_in(0, 8'h00, 0, EMPTY, 0, 0);
        checks++; if (uart_dat_re !== 1'b0) begin errors++; $display("FAIL rxs_re_after got=%b want=0", uart_dat_re); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rxs_valid got=%b want=1", rx_valid); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rxs_data got=%h want=3c", rx_data); end
        checks++; if (rx_level !== 5'd1) begin errors++; $display("FAIL rxs_level got=%0d want=1", rx_level); end
        set_in(0, 8'h00, 0, EMPTY, 1, 0);
        tick();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rxs_pop_valid got=%b want=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rxs_pop_data got=%h want=00", rx_data); end
    endtask

    task automatic test_rx_full();
        for (int i = 0; i < RXD; i++) begin
            set_in(0, 8'h00, 0, {24'h0, 8'($urandom_range(255))}, 0, 0);
            tick();
        end
        checks++; if (rx_level !== 5'd16) begin errors++; $display("FAIL rxf_level got=%0d want=16", rx_level); end
        set_in(0, 8'h00, 0, 32'h0000_00EE, 0, 0);
        checks++; if (uart_dat_re !== DROP) begin errors++; $display("FAIL rxf_re got=%b want=%b", uart_dat_re, DROP); end
        tick();
        set_in(0, 8'h00, 0, EMPTY, 0, 0);
        checks++; if (rx_level !== 5'd16) begin errors++; $display("FAIL rxf_level_after got=%0d want=16", rx_level); end
        checks++; if (rx_overrun !== DROP) begin errors++; $display("FAIL rxf_overrun got=%b want=%b", rx_overrun, DROP); end
        checks++; if (rx_data !== rq[0]) begin errors++; $display("FAIL rxf_head got=%h want=%h", rx_data, rq[0]); end
        set_in(0, 8'h00, 0, 32'h0000_00EE, 0, 1);
        tick();
        checks++; if (rx_overrun !== m_ovr) begin errors++; $display("FAIL rxf_set_wins got=%b want=%b", rx_overrun, m_ovr); end
        set_in(0, 8'h00, 0, EMPTY, 0, 1);
        tick();
        checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL rxf_clear got=%b want=0", rx_overrun); end
        for (int i = 0; i < RXD; i++) begin
            set_in(0, 8'h00, 0, EMPTY, 1, 0);
            checks++; if (rx_data !== rq[0]) begin errors++; $display("FAIL rxf_drain_data got=%h want=%h", rx_data, rq[0]); end
            tick();
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rxf_drained_valid got=%b want=0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        bit [31:0] dd;
        bit [7:0]  ex_di, ex_rd;
        for (int c = 0; c < 400; c++) begin
            dd = ($urandom_range(2) == 0) ? EMPTY : {24'h0, 8'($urandom_range(255))};
            set_in(1'($urandom_range(1)), 8'($urandom_range(255)), ($urandom_range(3) == 0),
                   dd, (c < 200) ? ($urandom_range(4) == 0) : 1'($urandom_range(1)),
                   ($urandom_range(7) == 0));
            ex_di = (tq.size() > 0) ? tq[0] : 8'h00;
            ex_rd = (rq.size() > 0) ? rq[0] : 8'h00;
            checks++; if (tx_ready !== (tq.size() < TXD)) begin errors++; $display("FAIL b2b_tx_ready c=%0d got=%b", c, tx_ready); end
            checks++; if (tx_level !== 5'(tq.size())) begin errors++; $display("FAIL b2b_tx_level c=%0d got=%0d want=%0d", c, tx_level, tq.size()); end
            checks++; if (uart_dat_di !== ex_di) begin errors++; $display("FAIL b2b_di c=%0d got=%h want=%h", c, uart_dat_di, ex_di); end
            checks++; if (uart_dat_we !== (tq.size() > 0)) begin errors++; $display("FAIL b2b_we c=%0d got=%b", c, uart_dat_we); end
            checks++; if (rx_level !== 5'(rq.size())) begin errors++; $display("FAIL b2b_rx_level c=%0d got=%0d want=%0d", c, rx_level, rq.size()); end
            checks++; if (rx_data !== ex_rd) begin errors++; $display("FAIL b2b_rx_data c=%0d got=%h want=%h", c, rx_data, ex_rd); end
            checks++; if (uart_dat_re !== ((dd[31:8] == 24'h0) && (DROP || rq.size() < RXD))) begin errors++; $display("FAIL b2b_re c=%0d got=%b", c, uart_dat_re); end
            checks++; if (rx_overrun !== m_ovr) begin errors++; $display("FAIL b2b_overrun c=%0d got=%b want=%b", c, rx_overrun, m_ovr); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 40; i++) begin
            set_in(0, 8'h00, 0, EMPTY, 1, 1);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1, 8'($urandom_range(255)), 1, (i < 3) ? {24'h0, 8'($urandom_range(255))} : EMPTY, 0, 0);
            tick();
        end
        checks++; if (tx_level !== 5'd5) begin errors++; $display("FAIL rst_pre_tx_level got=%0d want=5", tx_level); end
        checks++; if (rx_level !== 5'd3) begin errors++; $display("FAIL rst_pre_rx_level got=%0d want=3", rx_level); end
        set_in(0, 8'h00, 1, EMPTY, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL rst_tx_level got=%0d want=0", tx_level); end
        checks++; if (rx_level !== 5'd0) begin errors++; $display("FAIL rst_rx_level got=%0d want=0", rx_level); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got=%b want=1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got=%b want=0", rx_valid); end
        checks++; if (uart_dat_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b want=0", uart_dat_we); end
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 8'h00, 0, EMPTY, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        test_reset();
        test_tx_order();
        test_tx_full();
        test_rx_single();
        test_rx_full();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
